prog_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the cpu and its 256x8 memory. It accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake and writes the payload into memory starting at address 0. It then zero-fills the remaining addresses and releases the cpu from reset. While the cpu is held in reset, a top-level mux gives the memory write port to this block.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/prog_loader.sv | 101 ++++++++++
 tb/tb_prog_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu/loader constants: loader states, memory depth, cpu opcodes
package cpu_pkg;

  localparam int MEM_DEPTH = 256;

  typedef enum logic [2:0] {
    LD_LEN   = 3'd0,
    LD_DATA  = 3'd1,
    LD_CHECK = 3'd2,
    LD_CLEAR = 3'd3,
    LD_RUN   = 3'd4,
    LD_ERROR = 3'd5
  } ld_state_e;

  // Opcode bytes understood by the cpu; 0x00 doubles as the NOP left by zero-fill.
  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_LDI      = 8'h61;
  localparam logic [7:0] OP_ADD      = 8'h22;
  localparam logic [7:0] OP_JMP      = 8'h6A;
  localparam logic [7:0] OP_OUT_HALT = 8'hE7;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream boot loader into cpu memory, then cpu release
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  chk_err
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL = CW'(MEM_DEPTH);

  ld_state_e             state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         len;
  logic [DATA_WIDTH-1:0] sum;
  logic                  xfer;

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= LD_LEN;
      cnt   <= '0;
      len   <= '0;
      sum   <= '0;
    end else begin
      case (state)
        LD_LEN: if (xfer) begin
          // A length byte of zero encodes a full-memory frame.
          len   <= (in_data == '0) ? FULL : CW'(in_data);
          cnt   <= '0;
          sum   <= '0;
          state <= LD_DATA;
        end
        LD_DATA: if (xfer) begin
          cnt <= cnt + CW'(1);
          sum <= sum + in_data;
          if (cnt + CW'(1) == len) state <= LD_CHECK;
        end
        LD_CHECK: if (xfer) begin
          if (in_data != sum)  state <= LD_ERROR;
          else if (len < FULL) state <= LD_CLEAR;
          else                 state <= LD_RUN;
        end
        LD_CLEAR: begin
          cnt <= cnt + CW'(1);
          if (cnt[ADDR_WIDTH-1:0] == '1) state <= LD_RUN;
        end
        LD_RUN, LD_ERROR: if (reload) state <= LD_LEN;
        default: state <= LD_LEN;
      endcase
    end
  end

  // Outputs are forced to their idle values whenever reset is held low,
  // even before the first reset edge has moved the state register.
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    cpu_reset = 1'b1;
    load_done = 1'b0;
    chk_err   = 1'b0;
    if (reset) begin
      case (state)
        LD_LEN, LD_CHECK: in_ready = 1'b1;
        LD_DATA: begin
          in_ready = 1'b1;
          mem_we   = in_valid;
          mem_addr = cnt[ADDR_WIDTH-1:0];
          mem_data = in_data;
        end
        LD_CLEAR: begin
          mem_we   = 1'b1;
          mem_addr = cnt[ADDR_WIDTH-1:0];
        end
        LD_RUN: begin
          cpu_reset = 1'b0;
          load_done = 1'b1;
        end
        LD_ERROR: chk_err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader with directed frames
module tb_prog_loader;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       reload;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       cpu_reset;
  logic       load_done;
  logic       chk_err;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  mem[256];
  logic [7:0]  exp_img[256];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .cpu_reset(cpu_reset), .load_done(load_done), .chk_err(chk_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every memory write must match the next expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_data;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h required=none", {mem_addr, mem_data});
      end else begin
        check("mem_write", {16'h0, mem_addr, mem_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check("gap_mem_we", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_in_ready", 32'(in_ready), 32'd1);
    check("reload_load_done", 32'(load_done), 32'd0);
    check("reload_chk_err", 32'(chk_err), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic [7:0] f[$], input bit gaps, input bit ok);
    int len;
    int n;
    int mism;
    len = (f[0] == 8'h00) ? 256 : int'(f[0]);
    send(f[0]);
    if (gaps) idle($urandom_range(1, 3));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({8'(i), f[1+i]});
      send(f[1+i]);
      if (gaps) idle($urandom_range(1, 3));
    end
    if (ok) for (int a = len; a < 256; a++) exp_q.push_back({8'(a), 8'h00});
    send(f[len+1]);
    if (ok) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!load_done && n < 400);
      check("run_latency", 32'(n), 32'(257 - len));
      check("run_cpu_reset", 32'(cpu_reset), 32'd0);
      check("run_in_ready", 32'(in_ready), 32'd0);
      check("run_chk_err", 32'(chk_err), 32'd0);
      check("run_mem_we", 32'(mem_we), 32'd0);
      for (int a = 0; a < 256; a++) exp_img[a] = (a < len) ? f[1+a] : 8'h00;
      mism = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== exp_img[a]) mism++;
      check("image_mismatches", 32'(mism), 32'd0);
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      check("err_chk_err", 32'(chk_err), 32'd1);
      check("err_cpu_reset", 32'(cpu_reset), 32'd1);
      check("err_in_ready", 32'(in_ready), 32'd0);
      check("err_load_done", 32'(load_done), 32'd0);
      in_valid = 1'b1;
      in_data  = 8'hFF;
      repeat (5) @(posedge clk);
      #1 in_valid = 1'b0;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    for (int a = 0; a < 256; a++) mem[a] = 8'hA5;
    reset = 1'b0; in_valid = 1'b1; in_data = 8'h55; reload = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_data", 32'(mem_data), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_chk_err", 32'(chk_err), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;

    // Nominal load: 0x61+0x22+0xE7 = 0x16A -> checksum 0x6A.
    fr = {8'h03, OP_LDI, OP_ADD, OP_OUT_HALT, 8'h6A};
    run_frame(fr, 1'b0, 1'b1);
    check("nominal_mem200", 32'(mem[200]), 32'h00);
    check("nominal_mem2", 32'(mem[2]), 32'hE7);
    pulse_reload();

    // Same frame with random gaps between bytes.
    for (int a = 0; a < 256; a++) mem[a] = 8'hA5;
    run_frame(fr, 1'b1, 1'b1);
    pulse_reload();

    // Bad checksum: 0x10+0x20 = 0x30, sent 0x31.
    fr = {8'h02, 8'h10, 8'h20, 8'h31};
    run_frame(fr, 1'b0, 1'b0);
    pulse_reload();

    // Full-size frame: bytes 0..255 sum to 0x7F80 -> checksum 0x80.
    fr = {8'h00};
    for (int i = 0; i < 256; i++) fr.push_back(8'(i));
    fr.push_back(8'h80);
    run_frame(fr, 1'b0, 1'b1);
    check("full_mem255", 32'(mem[255]), 32'hFF);
    pulse_reload();

    // Reset after two of five data bytes.
    send(8'h05);
    exp_q.push_back({8'h00, 8'h11});
    send(8'h11);
    exp_q.push_back({8'h01, 8'h22});
    send(8'h22);
    in_valid = 1'b1;
    in_data  = 8'h33;
    reset    = 1'b0;
    @(negedge clk);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_mem_addr", 32'(mem_addr), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_len_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    fr = {8'h03, OP_LDI, OP_ADD, OP_OUT_HALT, 8'h6A};
    run_frame(fr, 1'b0, 1'b1);
    pulse_reload();

    // Single-instruction program.
    fr = {8'h01, OP_OUT_HALT, 8'hE7};
    run_frame(fr, 1'b0, 1'b1);
    check("halt_mem0", 32'(mem[0]), 32'hE7);
    check("halt_mem1", 32'(mem[1]), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
